// File: rtl/mod_controller_pkg.sv
// mod_controller_pkg: button indices and controller state encoding shared by host and device ends
package mod_controller_pkg;
  localparam int NUM_BUTTONS = 8;
  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP = 4;
  localparam int BTN_DOWN = 5;
  localparam int BTN_LEFT = 6;
  localparam int BTN_RIGHT = 7;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} ctrl_state_t;
endpackage

// File: rtl/mod_input_filter.sv
// mod_input_filter: 2-flop synchroniser, glitch filter and registered rise/fall strobes for one async line
module mod_input_filter #(
  parameter int GLITCH_CYCLES = 2
) (
  input  logic in_clk,
  input  logic in_reset,
  input  logic in_async,
  output logic out_rise,
  output logic out_fall
);
  logic [1:0] sync;
  logic level, level_d;
  logic [3:0] cnt;
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      sync <= '0;
      level <= 1'b0;
      level_d <= 1'b0;
      cnt <= '0;
      out_rise <= 1'b0;
      out_fall <= 1'b0;
    end else begin
      sync <= {sync[0], in_async};
      level_d <= level;
      out_rise <= level & ~level_d;
      out_fall <= ~level & level_d;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == 4'(GLITCH_CYCLES - 1)) begin
        level <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: rtl/mod_controller_device.sv
// mod_controller_device: device end of the NES controller serial link, shifting out button state on latch/pulse
module mod_controller_device
  import mod_controller_pkg::*;
#(
  parameter int GLITCH_CYCLES = 2,
  parameter int FRAME_COUNT_W = 16
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic                     in_controller_latch,
  input  logic                     in_controller_pulse,
  input  logic [NUM_BUTTONS-1:0]   in_buttons,
  output logic                     out_controller_data,
  output logic [NUM_BUTTONS-1:0]   out_buttons_latched,
  output logic [3:0]               out_bit_index,
  output logic [FRAME_COUNT_W-1:0] out_frame_count,
  output logic                     out_overrun
);
  ctrl_state_t state;
  logic [NUM_BUTTONS-2:0] shift;
  logic latch_rise, latch_fall, pulse_rise, unused_pulse_fall, last;
  assign last = out_bit_index == 4'(NUM_BUTTONS - 1);
  mod_input_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_latch (
    .in_clk(in_clk), .in_reset(in_reset), .in_async(in_controller_latch),
    .out_rise(latch_rise), .out_fall(latch_fall)
  );
  mod_input_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_pulse (
    .in_clk(in_clk), .in_reset(in_reset), .in_async(in_controller_pulse),
    .out_rise(pulse_rise), .out_fall(unused_pulse_fall)
  );
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state <= ST_IDLE;
      shift <= '0;
      out_controller_data <= 1'b1;
      out_buttons_latched <= '0;
      out_bit_index <= '0;
      out_frame_count <= '0;
      out_overrun <= 1'b0;
    end else if (latch_rise) begin
      state <= ST_LOAD;
      shift <= in_buttons[NUM_BUTTONS-1:1];
      out_controller_data <= ~in_buttons[BTN_A];
      out_overrun <= 1'b0;
    end else if (state == ST_LOAD) begin
      shift <= in_buttons[NUM_BUTTONS-1:1];
      out_controller_data <= ~in_buttons[BTN_A];
      if (latch_fall) begin
        state <= ST_SHIFT;
        out_buttons_latched <= in_buttons;
        out_bit_index <= '0;
        out_frame_count <= out_frame_count + FRAME_COUNT_W'(1);
      end
    end else if (pulse_rise && state == ST_SHIFT) begin
      shift <= shift >> 1;
      out_bit_index <= out_bit_index + 4'd1;
      out_controller_data <= last ? 1'b0 : ~shift[0];
      state <= last ? ST_DONE : ST_SHIFT;
    end else if (pulse_rise && state == ST_DONE) begin
      out_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mod_controller_device.sv
// tb_mod_controller_device: scoreboard bench for the NES controller device emulator
module tb_mod_controller_device;
  typedef struct packed {
    logic       d;
    logic [7:0] l;
    logic [3:0] i;
    logic [3:0] c;
    logic       o;
  } snap_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic latch = 1'b0;
  logic pulse = 1'b0;
  logic [7:0] btn = 8'hA5;
  logic data, ovr;
  logic [7:0] latched;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic go = 1'b0;
  int total = 0;
  int bad = 0;
  snap_t sb [$];
  snap_t cur;
  logic seq81 [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  assign cur = {data, latched, idx, cnt, ovr};
  always #5 clk = ~clk;
  mod_controller_device #(.GLITCH_CYCLES(2), .FRAME_COUNT_W(4)) dut (
    .in_clk(clk),
    .in_reset(rst),
    .in_controller_latch(latch),
    .in_controller_pulse(pulse),
    .in_buttons(btn),
    .out_controller_data(data),
    .out_buttons_latched(latched),
    .out_bit_index(idx),
    .out_frame_count(cnt),
    .out_overrun(ovr)
  );
  function automatic snap_t mk(logic d, logic [7:0] l, logic [3:0] i, logic [3:0] c, logic o);
    return {d, l, i, c, o};
  endfunction
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic latch_once(int hi, int lo);
    latch = 1'b1;
    cyc(hi);
    latch = 1'b0;
    cyc(lo);
  endtask
  task automatic pulse_once(int hi, int lo);
    pulse = 1'b1;
    cyc(hi);
    pulse = 1'b0;
    cyc(lo);
  endtask
  task automatic chk_empty(string name);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s: pending expected changes=%0d, required 0", name, sb.size());
      sb.delete();
    end
  endtask
  task automatic chk(string name, logic [7:0] got, logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask
  task automatic mon_check(snap_t c);
    snap_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_unexpected: got d=%b l=%h i=%0d c=%0d o=%b, required no change", c.d, c.l, c.i, c.c, c.o);
    end else begin
      e = sb.pop_front();
      if (c !== e) begin
        bad++;
        $display("FAIL sb_out: got d=%b l=%h i=%0d c=%0d o=%b, required d=%b l=%h i=%0d c=%0d o=%b",
                 c.d, c.l, c.i, c.c, c.o, e.d, e.l, e.i, e.c, e.o);
      end
    end
  endtask
  initial begin
    snap_t prev;
    wait (go);
    @(negedge clk);
    prev = cur;
    mon_check(prev);
    forever begin
      @(negedge clk);
      if (cur !== prev) begin
        mon_check(cur);
        prev = cur;
      end
    end
  end
  initial begin
    sb.push_back(mk(1'b1, 8'h00, 4'd0, 4'd0, 1'b0));
    cyc(4);
    rst = 1'b0;
    go = 1'b1;
    cyc(10);
    chk_empty("reset_idle");
    btn = 8'h81;
    sb.push_back(mk(1'b0, 8'h00, 4'd0, 4'd0, 1'b0));
    sb.push_back(mk(1'b0, 8'h81, 4'd0, 4'd1, 1'b0));
    latch_once(6, 8);
    for (int k = 1; k <= 8; k++) begin
      sb.push_back(mk(seq81[k-1], 8'h81, 4'(k), 4'd1, 1'b0));
      if (k == 3) btn = 8'hFF;
      pulse_once(6, 6);
    end
    chk_empty("frame_81");
    sb.push_back(mk(1'b0, 8'h81, 4'd8, 4'd1, 1'b1));
    repeat (10) pulse_once(6, 6);
    chk_empty("overrun");
    btn = 8'h02;
    sb.push_back(mk(1'b1, 8'h81, 4'd8, 4'd1, 1'b0));
    sb.push_back(mk(1'b1, 8'h02, 4'd0, 4'd2, 1'b0));
    latch_once(6, 8);
    sb.push_back(mk(1'b0, 8'h02, 4'd1, 4'd2, 1'b0));
    pulse_once(6, 6);
    sb.push_back(mk(1'b1, 8'h02, 4'd2, 4'd2, 1'b0));
    pulse_once(6, 6);
    chk_empty("frame_02");
    repeat (3) begin
      pulse = 1'b1;
      cyc(1);
      pulse = 1'b0;
      cyc(8);
    end
    chk_empty("glitch");
    btn = 8'h00;
    latch = 1'b1;
    pulse = 1'b1;
    cyc(3);
    pulse = 1'b0;
    cyc(6);
    chk("collide_idx", {4'd0, idx}, 8'd2);
    chk("collide_data", {7'd0, data}, 8'd1);
    sb.push_back(mk(1'b0, 8'h02, 4'd2, 4'd2, 1'b0));
    btn = 8'h01;
    cyc(1);
    chk("load_follow", {7'd0, data}, 8'd0);
    cyc(3);
    sb.push_back(mk(1'b0, 8'h01, 4'd0, 4'd3, 1'b0));
    latch = 1'b0;
    cyc(8);
    for (int k = 1; k <= 4; k++) begin
      sb.push_back(mk(1'b1, 8'h01, 4'(k), 4'd3, 1'b0));
      pulse_once(6, 6);
    end
    chk_empty("frame_01");
    sb.push_back(mk(1'b1, 8'h00, 4'd0, 4'd0, 1'b0));
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(10);
    chk_empty("reset_mid");
    btn = 8'h00;
    for (int k = 1; k <= 16; k++) begin
      sb.push_back(mk(1'b1, 8'h00, 4'd0, 4'(k), 1'b0));
      latch_once(4, 4);
    end
    cyc(20);
    chk("wrap", {4'd0, cnt}, 8'd0);
    chk_empty("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
